// File: rtl/signed_div_seq_pkg.sv
// Shared ALU package: FSM state encoding and default datapath width for the
// sequential signed divider.
package signed_div_seq_pkg;

  // Default operand / result width in bits.
  localparam int DEFAULT_WIDTH = 16;

  // Divider control states; IDLE must encode as zero.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    ITER = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/AbsoluteValue.sv
// Two's-complement magnitude. The result is read as unsigned, so the most
// negative input maps to 2^(W-1) without any special case.
module AbsoluteValue #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  output logic [W-1:0] value_o
);

  assign value_o = value_i[W-1] ? (~value_i + 1'b1) : value_i;

endmodule

// File: rtl/GiveSign.sv
// Applies a sign to a magnitude: negates (~x + 1, modulo 2^W) when requested.
module GiveSign #(
  parameter int W = 16
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] value_o
);

  assign value_o = negate_i ? (~value_i + 1'b1) : value_i;

endmodule

// File: rtl/signed_div_seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep the difference only when it is non-negative.
module div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dmag_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem_i[W-1:0], bit_i};
  // The partial remainder always stays below the divisor, so rem_i[W] is zero
  // in operation; folding it in keeps the compare correct for any input.
  assign qbit_o  = rem_i[W] | (shifted >= {1'b0, dmag_i});
  assign trial   = shifted - {1'b0, dmag_i};
  assign rem_o   = qbit_o ? trial : shifted;

endmodule

// File: rtl/signed_div_seq.sv
// Sequential signed divider (truncating toward zero) with valid/ready
// handshakes. Operands are converted to magnitudes, divided with l restoring
// steps, then the quotient and remainder signs are reapplied.
module signed_div_seq
  import signed_div_seq_pkg::*;
#(
  parameter int l = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [l-1:0] dividend,
  input  logic [l-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [l-1:0] quotient,
  output logic [l-1:0] remainder,
  output logic         div0,
  output logic         ovf
);

  localparam int CW = (l > 1) ? $clog2(l) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(l - 1);
  localparam logic [l-1:0]  MIN_VAL  = {1'b1, {(l-1){1'b0}}};

  div_state_e  state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [l-1:0] quotient_q;
  logic [l-1:0] remainder_q;
  logic        div0_q;
  logic        ovf_q;
  logic [CW-1:0] cnt_q;
  logic [l-1:0] dividend_q;
  logic [l-1:0] divisor_q;
  logic        sq_q;
  logic        sr_q;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so it ends up holding |quotient|.
  logic [l-1:0] a_q;
  logic [l-1:0] dmag_q;
  logic [l:0]   rem_q;

  logic [l-1:0] dividend_abs;
  logic [l-1:0] divisor_abs;
  logic [l:0]   step_rem;
  logic         step_qbit;
  logic [l-1:0] q_signed;
  logic [l-1:0] r_signed;

  AbsoluteValue #(.W(l)) u_abs_dividend (
    .value_i (dividend_q),
    .value_o (dividend_abs)
  );

  AbsoluteValue #(.W(l)) u_abs_divisor (
    .value_i (divisor_q),
    .value_o (divisor_abs)
  );

  div_step #(.W(l)) u_step (
    .rem_i  (rem_q),
    .bit_i  (a_q[l-1]),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  GiveSign #(.W(l)) u_sign_quotient (
    .value_i  (a_q),
    .negate_i (sq_q),
    .value_o  (q_signed)
  );

  GiveSign #(.W(l)) u_sign_remainder (
    .value_i  (rem_q[l-1:0]),
    .negate_i (sr_q),
    .value_o  (r_signed)
  );

  // Control FSM and datapath registers, with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      a_q         <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            sq_q       <= dividend[l-1] ^ divisor[l-1];
            sr_q       <= dividend[l-1];
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ABS;
          end
        end
        ABS: begin
          a_q    <= dividend_abs;
          dmag_q <= divisor_abs;
          rem_q  <= '0;
          cnt_q  <= CNT_LAST;
          ovf_q  <= (dividend_q == MIN_VAL) && (divisor_q == '1);
          if (divisor_q == '0) begin
            div0_q      <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= dividend_q;
            state_q     <= DONE;
          end else begin
            state_q <= ITER;
          end
        end
        ITER: begin
          rem_q <= step_rem;
          a_q   <= {a_q[l-2:0], step_qbit};
          if (cnt_q == '0) begin
            state_q <= SIGN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SIGN: begin
          quotient_q  <= q_signed;
          remainder_q <= r_signed;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Divide-by-zero arrives here straight from ABS with out_valid low;
          // raising it one cycle later fixes that path's latency at two cycles.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div0      = div0_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Directed self-checking bench for signed_div_seq at l = 16.
module tb_signed_div_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div0;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  signed_div_seq #(.l(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands on a falling edge; the next rising edge accepts them.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    chk({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges after acceptance until out_valid is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic d0, input logic ov);
    chk({tag, ".quotient"},  32'(quotient),  32'(q));
    chk({tag, ".remainder"}, 32'(remainder), 32'(r));
    chk({tag, ".div0"},      32'(div0),      32'(d0));
    chk({tag, ".ovf"},       32'(ovf),       32'(ov));
  endtask

  // Full operation with out_ready held high: latency, result, return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] q, input logic [15:0] r,
                        input logic d0, input logic ov, input int lat);
    int cyc;
    start_op(tag, a, b);
    wait_done(cyc);
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
    check_result(tag, q, r, d0, ov);
    chk({tag, ".in_ready_in_done"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
    $display("op %s: %0h / %0h -> q=%0h r=%0h div0=%0b ovf=%0b lat=%0d",
             tag, a, b, quotient, remainder, div0, ovf, cyc);
  endtask

  initial begin
    int cyc;
    logic [15:0] hold_q;
    logic [15:0] hold_r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 16'h0000;
    divisor   = 16'h0000;
    out_ready = 1'b1;

    // Reset state.
    #12;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.quotient",  32'(quotient),  32'd0);
    chk("rst.remainder", 32'(remainder), 32'd0);
    chk("rst.div0",      32'(div0),      32'd0);
    chk("rst.ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sign combinations and truncation toward zero.
    run_op("100/7",    16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0, 18);
    run_op("-100/7",   16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0, 1'b0, 18);
    run_op("100/-7",   16'd100,   16'hFFF9,  16'hFFF2,  16'h0002,  1'b0, 1'b0, 18);
    run_op("-100/-7",  16'hFF9C,  16'hFFF9,  16'd14,    16'hFFFE,  1'b0, 1'b0, 18);
    run_op("7/100",    16'd7,     16'd100,   16'd0,     16'd7,     1'b0, 1'b0, 18);

    // Most-negative boundaries.
    run_op("MIN/-1",   16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0, 1'b1, 18);
    run_op("MIN/1",    16'h8000,  16'h0001,  16'h8000,  16'h0000,  1'b0, 1'b0, 18);
    run_op("MIN/MIN",  16'h8000,  16'h8000,  16'h0001,  16'h0000,  1'b0, 1'b0, 18);
    run_op("MAX/MIN",  16'h7FFF,  16'h8000,  16'h0000,  16'h7FFF,  1'b0, 1'b0, 18);

    // Divide by zero, right after an overflow to show the flags are cleared.
    run_op("MIN/-1b",  16'h8000,  16'hFFFF,  16'h8000,  16'h0000,  1'b0, 1'b1, 18);
    run_op("1234/0",   16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 1'b0, 2);
    run_op("-5/0",     16'hFFFB,  16'd0,     16'hFFFF,  16'hFFFB,  1'b1, 1'b0, 2);

    // Back-pressure in DONE plus input noise during ITER.
    out_ready = 1'b0;
    start_op("stall", 16'd100, 16'd7);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (cyc < 12) begin
        in_valid = cyc[0];
        dividend = 16'd999 + 16'(cyc);
        divisor  = 16'd3;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stall.latency", 32'(cyc), 32'd18);
    check_result("stall", 16'd14, 16'd2, 1'b0, 1'b0);
    hold_q = quotient;
    hold_r = remainder;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall.out_valid_held", 32'(out_valid), 32'd1);
      chk("stall.in_ready_held",  32'(in_ready),  32'd0);
      chk("stall.quotient_held",  32'(quotient),  32'(hold_q));
      chk("stall.remainder_held", 32'(remainder), 32'(hold_r));
    end
    $display("op stall: held q=%0h r=%0h for 5 cycles", quotient, remainder);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall.out_valid_after", 32'(out_valid), 32'd0);
    chk("stall.in_ready_after",  32'(in_ready),  32'd1);

    // Reset during the 5th ITER cycle abandons the operation.
    start_op("abort", 16'd300, 16'd7);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready",  32'(in_ready),  32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.quotient",  32'(quotient),  32'd0);
    chk("abort.remainder", 32'(remainder), 32'd0);
    chk("abort.div0",      32'(div0),      32'd0);
    chk("abort.ovf",       32'(ovf),       32'd0);
    $display("op abort: reset mid-ITER, in_ready=%0b out_valid=%0b", in_ready, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("50/5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0, 18);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_div_seq.md
SIGNED_DIV_SEQ -- requirements
Module: signed_div_seq

Interface
REQ-001 SHALL have parameter l, default 16, meaning the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is presented.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port dividend, input, l bits, two's complement.
REQ-007 SHALL have port divisor, input, l bits, two's complement.
REQ-008 SHALL have port out_valid, output, 1 bit: the result outputs are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port quotient, output, l bits, two's complement.
REQ-011 SHALL have port remainder, output, l bits, two's complement.
REQ-012 SHALL have port div0, output, 1 bit: the divisor was zero.
REQ-013 SHALL have port ovf, output, 1 bit: the operation was most-negative / -1.

Function
REQ-014 SHALL implement the FSM states IDLE, ABS, ITER, SIGN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; an operation is accepted on the edge where in_valid && in_ready.
REQ-016 On acceptance, SHALL register the operands and the signs: sq = dividend[l-1]^divisor[l-1], sr = dividend[l-1]; next state ABS.
REQ-017 ABS, 1 cycle: SHALL load the magnitudes |dividend| and |divisor| as l-bit unsigned values, with |MIN| = 2^(l-1); SHALL clear the partial remainder and load the iteration counter with l-1.
REQ-018 ABS with divisor == 0: SHALL set div0, quotient = all ones, remainder = dividend (unmodified), skip ITER and SIGN, and go to DONE.
REQ-019 ITER, exactly l cycles: each cycle SHALL perform one restoring step, MSB first.
REQ-019a Each step: shift the partial remainder left by one, bringing in the next dividend bit; trial-subtract the divisor magnitude; if the result is non-negative, keep it and set the quotient bit, otherwise restore.
REQ-019b The partial remainder SHALL be l+1 bits wide.
REQ-019c After the counter reaches 0, the next state SHALL be SIGN.
REQ-020 SIGN, 1 cycle: quotient = sq ? -q : q; remainder = sr ? -r : r.
REQ-020a Negation SHALL be the two's-complement ~x+1, modulo 2^l.
REQ-020b Division SHALL truncate toward zero.
REQ-021 ovf SHALL be 1 iff dividend == MIN and divisor == -1; the result is then quotient = MIN (wrapped) and remainder = 0.
REQ-022 DONE: out_valid = 1, and quotient, remainder, div0 and ovf SHALL hold stable until out_valid && out_ready; then the next state SHALL be IDLE.
REQ-023 Latency SHALL be: out_valid rises l+2 cycles after the acceptance edge for normal operations, and 2 cycles after it for divide-by-zero.
REQ-024 in_valid SHALL be ignored outside IDLE; operand changes during an operation SHALL have no effect.
REQ-025 If out_ready is already 1 when DONE is entered, the block SHALL return to IDLE after one cycle of out_valid.
REQ-025a A new operation can be accepted at the earliest on the cycle after IDLE is re-entered.
REQ-026 div0 and ovf SHALL be cleared when a new operation is accepted.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force: state IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div0 = 0, ovf = 0, counter = 0.
REQ-028 Reset in any state, including mid-ITER, SHALL abandon the operation with no result delivered; the first acceptance is possible on the first edge after rst_n goes high.

Structure
REQ-029 The state encoding (3-bit, IDLE = 0) and the default width constant SHALL live in the shared ALU package.
REQ-030 Magnitude and sign application SHALL reuse the existing AbsoluteValue and GiveSign blocks, each at width l.
REQ-031 One new sub-module, div_step, SHALL be used: combinational, taking (partial remainder, next dividend bit, divisor magnitude) and giving (new partial remainder, quotient bit).

Verification
REQ-032 l=16: 100 / 7 -> quotient 14, remainder 2, div0 = 0, ovf = 0, out_valid exactly 18 cycles after acceptance.
REQ-033 l=16: -100 / 7 -> quotient 0xFFF2, remainder 0xFFFE; 100 / -7 -> quotient 0xFFF2, remainder 0x0002.
REQ-034 l=16: 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0, ovf = 1; 0x8000 / 1 -> quotient 0x8000, remainder 0, ovf = 0.
REQ-035 l=16: 1234 / 0 -> div0 = 1, quotient 0xFFFF, remainder 1234, out_valid 2 cycles after acceptance.
REQ-036 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; toggle in_valid with new operands during ITER -> result unaffected.
REQ-037 Assert rst_n low in the 5th ITER cycle -> outputs zero and in_ready = 1 at once; the next operation 50 / 5 -> quotient 10, remainder 0.
